// File: rtl/aes_pkg.sv
// Shared constants and FSM encodings for the AES-256 round sequencer.
package aes_pkg;
  localparam int NR = 14;
  localparam int NK = NR + 1;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    K_NONE,
    K_START,
    K_WAIT,
    K_EXP,
    K_SETTLE,
    K_FULL
  } key_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } blk_state_t;
endpackage

// File: rtl/aes_key_avail_tracker.sv
// Key FSM: launches the key controller and counts how many round keys are
// guaranteed written; the count trails the controller's writes by one cycle.
module aes_key_avail_tracker #(
  parameter int NK_P     = aes_pkg::NK,
  parameter int KEY_PACE = 2,
  parameter int SETTLE   = 2
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic       key_load,
  input  logic       blk_idle,
  input  logic       key_ready,
  output logic       key_ack,
  output logic       key_ctrl_en,
  output logic       key_enc_ok,
  output logic       key_busy,
  output logic       key_full,
  output logic [3:0] key_avail
);
  import aes_pkg::*;

  localparam int PW = (KEY_PACE > 1) ? $clog2(KEY_PACE) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [3:0] NK_W = 4'(NK_P);

  key_state_t    state, state_nxt;
  logic [PW-1:0] pace;
  logic [SW-1:0] settle_cnt;
  logic [3:0]    avail;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state      <= K_NONE;
      pace       <= '0;
      settle_cnt <= '0;
      avail      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        // a new key invalidates every previously counted round key
        K_NONE, K_FULL: if (key_ack) avail <= '0;
        K_WAIT: if (key_ready) begin
          avail <= 4'd2;
          pace  <= '0;
        end
        K_EXP: begin
          settle_cnt <= '0;
          if (avail != NK_W) begin
            if (pace == PW'(KEY_PACE - 1)) begin
              pace  <= '0;
              avail <= avail + 4'd1;
            end else begin
              pace <= pace + 1'b1;
            end
          end
        end
        K_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    key_ack     = 1'b0;
    key_ctrl_en = 1'b0;
    case (state)
      K_NONE, K_FULL: begin
        key_ack = srst_n && key_load && blk_idle;
        if (key_ack) state_nxt = K_START;
      end
      K_START: begin
        key_ctrl_en = 1'b1;
        state_nxt   = K_WAIT;
      end
      K_WAIT:   if (key_ready) state_nxt = K_EXP;
      K_EXP:    if (avail == NK_W) state_nxt = K_SETTLE;
      K_SETTLE: if (settle_cnt == SW'(SETTLE - 1)) state_nxt = K_FULL;
      default:  state_nxt = K_NONE;
    endcase
  end

  assign key_avail  = avail;
  assign key_full   = (avail == NK_W);
  assign key_enc_ok = state inside {K_EXP, K_SETTLE, K_FULL};
  assign key_busy   = !(state inside {K_NONE, K_FULL});
endmodule

// File: rtl/aes_round_seq.sv
// Control sequencer for one AES-256 block: key expansion launch, round
// stepping of an external single-round datapath, and block handshakes.
module aes_round_seq #(
  parameter int NR       = 14,
  parameter int KEY_PACE = 2,
  parameter int SETTLE   = 2
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic       key_load,
  output logic       key_ack,
  output logic       key_ctrl_en,
  output logic       key_mode,
  input  logic       key_ready,
  output logic [3:0] round,
  input  logic       in_valid,
  input  logic       in_mode,
  output logic       in_ready,
  output logic       dp_load,
  output logic       dp_round_en,
  output logic       dp_first,
  output logic       dp_last,
  output logic       dp_inv,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);
  import aes_pkg::*;

  localparam logic [3:0] LAST = 4'(NR);

  blk_state_t state, state_nxt;
  logic       mode;
  logic [3:0] rc;
  logic [3:0] key_avail;
  logic       key_full, key_enc_ok, key_busy, blk_idle, key_win;

  assign blk_idle = (state == S_IDLE);
  assign key_win  = key_load && key_ack;
  assign key_mode = 1'b0;
  assign busy     = !blk_idle || key_busy;

  aes_key_avail_tracker #(
    .NK_P     (NR + 1),
    .KEY_PACE (KEY_PACE),
    .SETTLE   (SETTLE)
  ) u_keys (
    .clk         (clk),
    .srst_n      (srst_n),
    .key_load    (key_load),
    .blk_idle    (blk_idle),
    .key_ready   (key_ready),
    .key_ack     (key_ack),
    .key_ctrl_en (key_ctrl_en),
    .key_enc_ok  (key_enc_ok),
    .key_busy    (key_busy),
    .key_full    (key_full),
    .key_avail   (key_avail)
  );

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state <= S_IDLE;
      mode  <= MODE_ENC;
      rc    <= '0;
    end else begin
      state <= state_nxt;
      if (dp_load) begin
        mode <= in_mode;
        rc   <= '0;
      end else if (dp_round_en) begin
        rc <= rc + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    dp_load     = 1'b0;
    dp_round_en = 1'b0;
    dp_first    = 1'b0;
    dp_last     = 1'b0;
    dp_inv      = 1'b0;
    out_valid   = 1'b0;
    round       = '0;
    case (state)
      S_IDLE: begin
        // encrypt can chase the expansion; decrypt starts from the last key
        in_ready = srst_n && !key_win &&
                   ((in_mode == MODE_DEC) ? key_full : key_enc_ok);
        if (in_valid && in_ready) begin
          dp_load   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        round = (mode == MODE_DEC) ? (LAST - rc) : rc;
        if ((mode == MODE_DEC) || (rc < key_avail)) begin
          dp_round_en = 1'b1;
          dp_first    = (rc == 4'd0);
          dp_last     = (rc == LAST);
          dp_inv      = mode;
          if (rc == LAST) state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Control-only sequencer for one AES-256 block operation. It launches key expansion in the AES key controller (key_ctrl_en / key_ready / round) and tracks how many round keys are valid.
- Steps an external single-round AES datapath through 15 round-key applications, encrypt or decrypt.
- Handles valid/ready handshakes at block input and output. Carries no 128-bit data itself.

Parameters:
NR, 14, number of cipher rounds; round keys indexed 0..NR
KEY_PACE, 2, cycles per newly generated round key in the key controller
SETTLE, 2, guard cycles after the last key before the key controller may be restarted

Ports:
clk  in  1  clock
srst_n  in  1  synchronous active-low reset
key_load  in  1  request to expand a new key (key bus wired directly to the key controller)
key_ack  out  1  key_load accepted this cycle
key_ctrl_en  out  1  one-cycle start pulse to the key controller
key_mode  out  1  key controller mode; constant 0 (early key_ready)
key_ready  in  1  one-cycle pulse from the key controller
round  out  4  round-key index presented to the key controller
in_valid  in  1  block available at datapath input
in_mode  in  1  0 encrypt, 1 decrypt
in_ready  out  1  block accepted when in_valid && in_ready
dp_load  out  1  datapath captures input block
dp_round_en  out  1  datapath applies one round using the current round key
dp_first  out  1  step is the initial AddRoundKey only
dp_last  out  1  step is the final round (no (Inv)MixColumns)
dp_inv  out  1  inverse-cipher operations
out_valid  out  1  result held in datapath
out_ready  in  1  consumer accepts result
busy  out  1  block FSM not idle, or key FSM not in K_NONE/K_FULL

Behaviour:
- Reset: every output 0. key_avail=0; both FSMs idle. Reset mid-operation aborts silently. The key controller shares srst_n.
- Key FSM states and transitions:
  - K_NONE: key_ack = key_load && block FSM idle. Accept -> K_START.
  - K_START: key_ctrl_en=1 for exactly 1 cycle -> K_WAIT.
  - K_WAIT: on key_ready -> key_avail<=2, pace<=0 -> K_EXP.
  - K_EXP: pace toggles each cycle; key_avail increments when pace==1. Reaching 15 -> K_SETTLE.
  - K_SETTLE: SETTLE cycles -> K_FULL.
  - K_FULL: same accept rule as K_NONE.
  - key_avail saturates at 15. The count is deliberately one cycle conservative against the key controller's write of each key.
- key_load is ignored (key_ack=0) outside K_NONE/K_FULL or while a block is in flight. It has priority over in_valid in the same cycle: in_ready=0 when key_load && key_ack.
- Block FSM states and transitions:
  - S_IDLE: in_ready=1 when there is no winning key_load and either (encrypt: key FSM in K_EXP/K_SETTLE/K_FULL) or (decrypt: key_avail==15). On accept: dp_load=1, latch mode, rc<=0 -> S_RUN.
  - S_RUN: round = mode ? 14-rc : rc. Step is permitted if encrypt and rc<key_avail, or decrypt (always, since key_avail is 15).
    - Permitted step: dp_round_en=1, dp_first=(rc==0), dp_last=(rc==14), dp_inv=mode, rc++.
    - Otherwise stall with all dp_* = 0.
    - Leaving: step with rc==14 -> S_OUT.
  - S_OUT: out_valid=1, held until out_ready -> S_IDLE. In S_OUT, dp_round_en=0 and the datapath holds its state.
- round=0 outside S_RUN.
- Latency with keys full: accept cycle T, steps T+1..T+15, out_valid from T+16. The next accept is possible in the cycle after the out handshake.
- Key load at cycle t: key_ctrl_en t+1, key_ready t+3, key_avail=2 at t+4, n at t+2n, 15 at t+30, K_FULL at t+33.
- The key bank is never rewritten while a block is in S_RUN/S_OUT.

Decomposition:
- Package aes_pkg holds:
  - constants NR=14, NK=15;
  - mode encodings MODE_ENC=0, MODE_DEC=1;
  - key FSM enum K_NONE/K_START/K_WAIT/K_EXP/K_SETTLE/K_FULL;
  - block FSM enum S_IDLE/S_RUN/S_OUT.
- One sub-module is natural: aes_key_avail_tracker, containing the key FSM, pace and key_avail, with outputs key_avail[3:0] and key_full.

Test Plan:
- Reset mid-expansion (t+10): all outputs 0 next cycle; in_ready=0 until a new key_load.
- key_load at t=0 in K_NONE: key_ack t0, key_ctrl_en only at t1, key_avail 2 at t4 and 15 at t30, K_FULL at t33; key_load at t20 -> key_ack=0.
- Encrypt with in_valid held from t0 after key_load t0: dp_load t4; rounds 0,1,2 at t5,t6,t7; round k (k>=3) at 2k+2; round 14 with dp_last at t30; out_valid t31.
- Decrypt after the same key_load: in_ready low until t30, accept t30, round sequence 14,13..0 at t31..t45 with dp_inv=1, dp_first at t31, dp_last at t45, out_valid t46.
- Keys full, encrypt accepted at T, out_ready low for 5 cycles: out_valid T+16..T+21, no dp_round_en; second block accepted T+22.
- key_load and in_valid together in K_FULL idle: key_ack=1, in_ready=0; block accepted at t+4 of the new key.
